// File: rtl/sqrt_pkg.sv
// rtl/sqrt_pkg.sv - shared types, latency and parameter checks for sqrt_seq
package sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } sqrt_state_e;

  // Request-to-completion latency in clocks: N recurrence cycles plus the output register stage.
  function automatic int sqrt_latency(input int width, input int spc);
    return width / (2 * spc) + 1;
  endfunction

  function automatic bit sqrt_params_ok(input int width, input int spc);
    return (width >= 4) && ((width % 2) == 0) && ((spc == 1) || (spc == 2)) &&
           (((width / 2) % spc) == 0);
  endfunction

endpackage

// File: rtl/sqrt_seq_if.sv
// rtl/sqrt_seq_if.sv - four-phase req/fin operand and result bundle for sqrt_seq
interface sqrt_seq_if #(
  parameter int WIDTH = 32
);
  logic               req;
  logic [WIDTH-1:0]   in;
  logic               fin;
  logic [WIDTH/2-1:0] out;
  logic [WIDTH/2:0]   rem;

  modport master (output req, output in, input fin, input out, input rem);
  modport slave  (input req, input in, output fin, output out, output rem);
endinterface

// File: rtl/sqrt_step.sv
// rtl/sqrt_step.sv - one combinational restoring square-root recurrence step
module sqrt_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH/2+1:0] rem_i,
  input  logic [WIDTH/2-1:0] root_i,
  input  logic [1:0]         bits_i,
  output logic [WIDTH/2+1:0] rem_o,
  output logic [WIDTH/2-1:0] root_o
);
  localparam int HW = WIDTH / 2;
  localparam int RW = HW + 2;

  logic [RW-1:0] shifted;
  logic [RW-1:0] trial;

  // The partial remainder never exceeds 2*root, so the dropped MSBs are always zero here.
  logic unused_msbs;
  assign unused_msbs = ^{rem_i[RW-1:RW-2], root_i[HW-1]};

  always_comb begin
    shifted = {rem_i[RW-3:0], bits_i};
    trial   = {root_i, 2'b01};
    if (shifted >= trial) begin
      rem_o  = shifted - trial;
      root_o = {root_i[HW-2:0], 1'b1};
    end else begin
      rem_o  = shifted;
      root_o = {root_i[HW-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/sqrt_seq.sv
// rtl/sqrt_seq.sv - clocked digit-recurrence integer square root with four-phase req/fin
// SQRT_ROUND_EN: round the root to nearest (saturating); rem stays the floor remainder.
module sqrt_seq #(
  parameter int WIDTH = 32,
  parameter int SPC   = 1
) (
  input logic       clk,
  input logic       rst_n,
  sqrt_seq_if.slave bus
);
  import sqrt_pkg::*;

  localparam int HW   = WIDTH / 2;
  localparam int RW   = HW + 2;
  localparam int LAT  = sqrt_latency(WIDTH, SPC);
  localparam int NCYC = LAT - 1;
  localparam int CW   = $clog2(NCYC + 1);

  if (!sqrt_params_ok(WIDTH, SPC)) begin : g_bad_params
    $error("sqrt_seq: WIDTH must be even and >= 4, SPC 1 or 2 dividing WIDTH/2");
  end

  sqrt_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [RW-1:0] prem_q, prem_d;
  logic [HW-1:0] proot_q, proot_d;
  logic [HW-1:0] out_q, out_d;
  logic [HW:0]   rem_q, rem_d;
  logic [HW-1:0] root_result;

  logic [RW-1:0] chain_rem  [SPC+1];
  logic [HW-1:0] chain_root [SPC+1];

  assign chain_rem[0]  = prem_q;
  assign chain_root[0] = proot_q;

  for (genvar s = 0; s < SPC; s++) begin : g_step
    sqrt_step #(.WIDTH(WIDTH)) u_step (
      .rem_i  (chain_rem[s]),
      .root_i (chain_root[s]),
      .bits_i (opnd_q[WIDTH-1-2*s -: 2]),
      .rem_o  (chain_rem[s+1]),
      .root_o (chain_root[s+1])
    );
  end

`ifdef SQRT_ROUND_EN
  always_comb begin
    root_result = proot_q;
    if ((prem_q[HW:0] > {1'b0, proot_q}) && (proot_q != '1))
      root_result = proot_q + 1'b1;
  end
`else
  assign root_result = proot_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.req) state_d = CALC;
      CALC:    if (!bus.req) state_d = IDLE;
               else if (cnt_q == CW'(NCYC)) state_d = DONE;
      DONE:    if (!bus.req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.fin = (state_q == DONE);
  end

  assign bus.out = out_q;
  assign bus.rem = rem_q;

  // cnt_q == NCYC marks the extra cycle that publishes the finished root and remainder.
  always_comb begin
    cnt_d   = cnt_q;
    opnd_d  = opnd_q;
    prem_d  = prem_q;
    proot_d = proot_q;
    out_d   = out_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: if (bus.req) begin
        opnd_d  = bus.in;
        prem_d  = '0;
        proot_d = '0;
        cnt_d   = '0;
      end
      CALC: if (bus.req) begin
        if (cnt_q == CW'(NCYC)) begin
          out_d = root_result;
          rem_d = prem_q[HW:0];
        end else begin
          prem_d  = chain_rem[SPC];
          proot_d = chain_root[SPC];
          opnd_d  = opnd_q << (2 * SPC);
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      opnd_q  <= '0;
      prem_q  <= '0;
      proot_q <= '0;
      out_q   <= '0;
      rem_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      opnd_q  <= opnd_d;
      prem_q  <= prem_d;
      proot_q <= proot_d;
      out_q   <= out_d;
      rem_q   <= rem_d;
    end
  end

endmodule

// File: tb/tb_sqrt_seq.sv
// tb/tb_sqrt_seq.sv - scoreboard bench for sqrt_seq (32-bit SPC=1 and 16-bit SPC=2 instances)
module tb_sqrt_seq;

  typedef struct {
    logic [15:0] out;
    logic [16:0] rem;
    longint      acc;
    int          lat;
  } sb_t;

  logic   clk;
  logic   rst_n;
  longint cyc;
  int     errors;
  int     checks;

  sb_t q32[$];
  sb_t q16[$];
  sb_t e32;
  sb_t e16;
  logic fin32_prev;
  logic fin16_prev;

  sqrt_seq_if #(.WIDTH(32)) if32 ();
  sqrt_seq_if #(.WIDTH(16)) if16 ();

  sqrt_seq #(.WIDTH(32), .SPC(1)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));
  sqrt_seq #(.WIDTH(16), .SPC(2)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic void model16(input int x, output logic [15:0] r_out, output logic [16:0] r_rem);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    r_rem = 17'(x - r * r);
`ifdef SQRT_ROUND_EN
    if ((x - r * r) > r && r != 255) r_out = 16'(r + 1);
    else r_out = 16'(r);
`else
    r_out = 16'(r);
`endif
  endfunction

  always @(negedge clk) begin : mon32
    if (if32.fin && !fin32_prev) begin
      if (q32.size() == 0) chk("unexpected_fin32", 1, 0);
      else begin
        e32 = q32.pop_front();
        chk("out32", if32.out, e32.out);
        chk("rem32", if32.rem, e32.rem);
        chk("lat32", cyc - e32.acc, e32.lat);
      end
    end
    fin32_prev = if32.fin;
  end

  always @(negedge clk) begin : mon16
    if (if16.fin && !fin16_prev) begin
      if (q16.size() == 0) chk("unexpected_fin16", 1, 0);
      else begin
        e16 = q16.pop_front();
        chk("out16", if16.out, e16.out[7:0]);
        chk("rem16", if16.rem, e16.rem[8:0]);
        chk("lat16", cyc - e16.acc, e16.lat);
      end
    end
    fin16_prev = if16.fin;
  end

  task automatic run32(input logic [31:0] x, input logic [15:0] eo, input logic [16:0] er);
    sb_t e;
    int n;
    e.out = eo; e.rem = er; e.acc = cyc + 1; e.lat = 17;
    q32.push_back(e);
    if32.in  = x;
    if32.req = 1'b1;
    n = 0;
    while (!if32.fin && n < 40) begin @(negedge clk); n++; end
    chk("timeout32", if32.fin, 1);
    if32.req = 1'b0;
    @(negedge clk);
    chk("fin_fall32", if32.fin, 0);
  endtask

  task automatic run16(input int x);
    sb_t e;
    int n;
    model16(x, e.out, e.rem);
    e.acc = cyc + 1; e.lat = 5;
    q16.push_back(e);
    if16.in  = 16'(x);
    if16.req = 1'b1;
    n = 0;
    while (!if16.fin && n < 20) begin @(negedge clk); n++; end
    chk("timeout16", if16.fin, 1);
    if16.req = 1'b0;
    @(negedge clk);
    chk("fin_fall16", if16.fin, 0);
  endtask

  initial begin : stim
    logic seen;
    errors = 0; checks = 0;
    fin32_prev = 1'b0; fin16_prev = 1'b0;
    rst_n = 1'b0;
    if32.req = 1'b0; if32.in = '0;
    if16.req = 1'b0; if16.in = '0;
    repeat (2) @(negedge clk);
    chk("rst_fin32", if32.fin, 0);
    chk("rst_out32", if32.out, 0);
    chk("rst_rem32", if32.rem, 0);
    chk("rst_fin16", if16.fin, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run32(32'd10454520, 16'd3233, 17'd2231);
    run32(32'd0, 16'd0, 17'd0);
    run32(32'hFFFF_FFFF, 16'd65535, 17'd131070);
`ifdef SQRT_ROUND_EN
    run32(32'd8, 16'd3, 17'd4);
`else
    run32(32'd8, 16'd2, 17'd4);
`endif

    if32.in = 32'd1000000; if32.req = 1'b1;
    repeat (6) @(negedge clk);
    if32.req = 1'b0;
    seen = 1'b0;
    repeat (25) begin @(negedge clk); if (if32.fin) seen = 1'b1; end
    chk("abort_fin", seen, 0);
`ifdef SQRT_ROUND_EN
    chk("abort_out_kept", if32.out, 3);
`else
    chk("abort_out_kept", if32.out, 2);
`endif
    chk("abort_rem_kept", if32.rem, 4);
    run32(32'd144, 16'd12, 17'd0);

    if32.in = 32'd1000; if32.req = 1'b1;
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_fin", if32.fin, 0);
    chk("midrst_out", if32.out, 0);
    chk("midrst_rem", if32.rem, 0);
    if32.req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run32(32'd49, 16'd7, 17'd0);

    for (int x = 0; x < 65536; x += 13) run16(x);
    run16(65535);
    run16(65025);
    run16(65024);

    repeat (3) @(negedge clk);
    chk("q32_drained", q32.size(), 0);
    chk("q16_drained", q16.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
